irq_priority_ctrl: RTL and testbench

//   Collects N external interrupt sources and drives the single e_irq input of the RISC core.

---
 rtl/irq_ctrl_pkg.sv | 18 +
 rtl/irq_src_sync.sv | 30 +++
 rtl/irq_priority_ctrl.sv | 143 ++++++++++++++
 tb/tb_irq_priority_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and register map for the interrupt priority controller.
// Imported by the controller top and its testbench.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    CLAIMED
  } irq_state_e;

  localparam logic [1:0] REG_ENABLE  = 2'd0;
  localparam logic [1:0] REG_TYPE    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_CLAIM   = 2'd3;

  localparam int ID_NONE = 0;

endpackage

// File: rtl/irq_src_sync.sv
// Per-source two-flop synchroniser plus an edge-detect flop.
// Produces the synchronised level and a one-cycle rising-edge pulse.
module irq_src_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq_src,
  output logic level,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= irq_src;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/irq_priority_ctrl.sv
// Fixed-priority interrupt controller with claim/complete handshake.
// Lowest source index wins; claim ID is index + 1, zero means none.
module irq_priority_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_irq_src,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  input  logic [3:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic             o_irq,
  output logic [ID_W-1:0]  o_irq_id
);

  logic [N_SRC-1:0] en_q;
  logic [N_SRC-1:0] type_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_n;
  logic [N_SRC-1:0] lvl;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] win_oh;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  claimed_q;
  logic [31:0]      rdata_n;

  irq_state_e state_q;
  irq_state_e state_n;

  logic sel_en;
  logic sel_type;
  logic sel_pend;
  logic sel_claim;
  logic claim_rd;
  logic complete;
  logic unused_bits;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_src_sync u_sync (
      .clk     (i_clk),
      .rst     (i_rst),
      .irq_src (i_irq_src[g]),
      .level   (lvl[g]),
      .rise    (rise[g])
    );
  end

  assign sel_en    = (i_addr[3:2] == REG_ENABLE);
  assign sel_type  = (i_addr[3:2] == REG_TYPE);
  assign sel_pend  = (i_addr[3:2] == REG_PENDING);
  assign sel_claim = (i_addr[3:2] == REG_CLAIM);

  assign active = pend_q & en_q;

  always_comb begin
    win_id = ID_W'(ID_NONE);
    win_oh = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_id    = ID_W'(i + 1);
        win_oh    = '0;
        win_oh[i] = 1'b1;
      end
    end
  end

  assign o_irq_id = win_id;

  assign claim_rd = i_rd_en & sel_claim
                  & (state_q == ASSERT) & (|active);
  assign complete = i_wr_en & sel_claim
                  & (state_q == CLAIMED)
                  & (i_wdata[ID_W-1:0] == claimed_q);

  // A fresh edge in the same cycle as its clear keeps the bit pending.
  assign clr = (claim_rd ? win_oh : '0)
             | ((i_wr_en & sel_pend) ? i_wdata[N_SRC-1:0] : '0);

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      pend_n[i] = type_q[i] ? ((pend_q[i] & ~clr[i]) | rise[i])
                            : lvl[i];
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (|active) state_n = ASSERT;
      end
      ASSERT: begin
        if (claim_rd)      state_n = CLAIMED;
        else if (~|active) state_n = IDLE;
      end
      CLAIMED: begin
        if (complete) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rdata_n = '0;
    unique case (1'b1)
      sel_en:    rdata_n[N_SRC-1:0] = en_q;
      sel_type:  rdata_n[N_SRC-1:0] = type_q;
      sel_pend:  rdata_n[N_SRC-1:0] = pend_q;
      sel_claim: rdata_n[ID_W-1:0]  = claim_rd ? win_id : '0;
      default:   rdata_n = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q      <= '0;
      type_q    <= '0;
      pend_q    <= '0;
      claimed_q <= '0;
      state_q   <= IDLE;
      o_irq     <= 1'b0;
      o_rdata   <= '0;
    end else begin
      state_q <= state_n;
      o_irq   <= (state_n == ASSERT);
      pend_q  <= pend_n;
      if (i_wr_en & sel_en)   en_q   <= i_wdata[N_SRC-1:0];
      if (i_wr_en & sel_type) type_q <= i_wdata[N_SRC-1:0];
      if (claim_rd)           claimed_q <= win_id;
      if (i_rd_en)            o_rdata <= rdata_n;
    end
  end

  assign unused_bits = ^{i_addr[1:0], i_wdata[31:N_SRC]};

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed testbench for irq_priority_ctrl.
// Hand-computed expectations for latency, priority and handshake.
module tb_irq_priority_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N_SRC = 8;
  localparam int ID_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_SRC-1:0] src;
  logic             wr_en;
  logic             rd_en;
  logic [3:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             irq;
  logic [ID_W-1:0]  irq_id;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  irq_priority_ctrl #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_irq_src (src),
    .i_wr_en   (wr_en),
    .i_rd_en   (rd_en),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_rdata   (rdata),
    .o_irq     (irq),
    .o_irq_id  (irq_id)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] sel, input logic [31:0] d);
    addr  = {sel, 2'b00};
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] sel, output logic [31:0] d);
    addr  = {sel, 2'b00};
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic pulse(input int idx);
    src[idx] = 1'b1;
    tick();
    src[idx] = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    src   = '0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = '0;
    wdata = '0;
    tick(2);
    rst = 1'b0;
    tick();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    // single edge source, latency and claim
    bus_wr(REG_ENABLE, 32'h01);
    bus_wr(REG_TYPE, 32'h01);
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    chk("lat_e0", 32'(irq), 32'd0);
    tick();
    chk("lat_e1", 32'(irq), 32'd0);
    tick();
    chk("lat_e2", 32'(irq), 32'd0);
    tick();
    chk("lat_e3", 32'(irq), 32'd1);
    chk("lat_id", 32'(irq_id), 32'd1);
    bus_rd(REG_CLAIM, rv);
    chk("t2_claim", rv, 32'd1);
    chk("t2_irq_lo", 32'(irq), 32'd0);
    bus_rd(REG_PENDING, rv);
    chk("t2_pend", rv, 32'd0);
    bus_wr(REG_CLAIM, 32'd1);
    tick(2);
    chk("t2_idle_irq", 32'(irq), 32'd0);
    bus_rd(REG_CLAIM, rv);
    chk("t2_idle_claim", rv, 32'd0);

    // priority between src5 and src2
    bus_wr(REG_ENABLE, 32'hFF);
    bus_wr(REG_TYPE, 32'hFF);
    src[5] = 1'b1;
    src[2] = 1'b1;
    tick(4);
    chk("t3_irq", 32'(irq), 32'd1);
    chk("t3_id", 32'(irq_id), 32'd3);
    bus_rd(REG_CLAIM, rv);
    chk("t3_claim_a", rv, 32'd3);
    bus_rd(REG_PENDING, rv);
    chk("t3_pend", rv, 32'h20);
    bus_wr(REG_CLAIM, 32'd3);
    chk("t3_gap", 32'(irq), 32'd0);
    tick();
    chk("t3_reassert", 32'(irq), 32'd1);
    bus_rd(REG_CLAIM, rv);
    chk("t3_claim_b", rv, 32'd6);
    bus_wr(REG_CLAIM, 32'd6);
    src = '0;
    tick(3);
    chk("t3_done", 32'(irq), 32'd0);

    // level source re-pends while held high
    bus_wr(REG_TYPE, 32'h00);
    src[1] = 1'b1;
    tick(4);
    chk("t4_irq", 32'(irq), 32'd1);
    bus_rd(REG_CLAIM, rv);
    chk("t4_claim_a", rv, 32'd2);
    bus_wr(REG_CLAIM, 32'd2);
    chk("t4_gap", 32'(irq), 32'd0);
    tick();
    chk("t4_repend", 32'(irq), 32'd1);
    bus_rd(REG_CLAIM, rv);
    chk("t4_claim_b", rv, 32'd2);
    src[1] = 1'b0;
    tick(4);
    bus_wr(REG_CLAIM, 32'd2);
    tick(3);
    chk("t4_low", 32'(irq), 32'd0);
    bus_rd(REG_PENDING, rv);
    chk("t4_pend", rv, 32'd0);

    // wrong complete ID is ignored
    bus_wr(REG_TYPE, 32'hFF);
    pulse(2);
    tick(3);
    chk("t5_irq", 32'(irq), 32'd1);
    bus_rd(REG_CLAIM, rv);
    chk("t5_claim", rv, 32'd3);
    bus_wr(REG_CLAIM, 32'd4);
    tick(2);
    chk("t5_irq_lo", 32'(irq), 32'd0);
    pulse(0);
    tick(3);
    chk("t5_held", 32'(irq), 32'd0);
    bus_rd(REG_PENDING, rv);
    chk("t5_pend", rv, 32'h01);
    bus_rd(REG_CLAIM, rv);
    chk("t5_claimed_rd", rv, 32'd0);
    bus_wr(REG_CLAIM, 32'd3);
    tick();
    chk("t5_reassert", 32'(irq), 32'd1);
    chk("t5_id", 32'(irq_id), 32'd1);
    bus_rd(REG_CLAIM, rv);
    chk("t5_claim_b", rv, 32'd1);
    bus_wr(REG_CLAIM, 32'd1);
    tick(2);

    // disabling the winner drops the request
    pulse(3);
    tick(3);
    chk("en_irq", 32'(irq), 32'd1);
    bus_wr(REG_ENABLE, 32'hF7);
    tick();
    chk("en_drop", 32'(irq), 32'd0);
    bus_wr(REG_PENDING, 32'h08);
    bus_wr(REG_ENABLE, 32'hFF);
    bus_rd(REG_PENDING, rv);
    chk("en_w1c", rv, 32'd0);
    tick(2);

    // new edge lands in the claim cycle
    pulse(0);
    tick(3);
    chk("t6_irq", 32'(irq), 32'd1);
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    tick();
    bus_rd(REG_CLAIM, rv);
    chk("t6_claim", rv, 32'd1);
    chk("t6_irq_lo", 32'(irq), 32'd0);
    bus_rd(REG_PENDING, rv);
    chk("t6_pend", rv, 32'h01);
    bus_wr(REG_CLAIM, 32'd1);
    tick();
    chk("t6_reassert", 32'(irq), 32'd1);
    bus_rd(REG_CLAIM, rv);
    chk("t6_claim_b", rv, 32'd1);
    bus_wr(REG_CLAIM, 32'd1);
    tick(2);
    chk("t6_quiet", 32'(irq), 32'd0);

    // reset in the middle of a claim
    pulse(0);
    tick(3);
    bus_rd(REG_CLAIM, rv);
    chk("t1_claim", rv, 32'd1);
    pulse(0);
    tick(3);
    bus_rd(REG_PENDING, rv);
    chk("t1_pend_pre", rv, 32'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_irq", 32'(irq), 32'd0);
    chk("t1_id", 32'(irq_id), 32'd0);
    chk("t1_rdata", rdata, 32'd0);
    bus_rd(REG_ENABLE, rv);
    chk("t1_en", rv, 32'd0);
    bus_rd(REG_TYPE, rv);
    chk("t1_type", rv, 32'd0);
    bus_rd(REG_PENDING, rv);
    chk("t1_pend", rv, 32'd0);
    bus_wr(REG_ENABLE, 32'h01);
    bus_wr(REG_TYPE, 32'h01);
    pulse(0);
    tick(3);
    chk("t1_idle_irq", 32'(irq), 32'd1);
    bus_rd(REG_CLAIM, rv);
    chk("t1_idle_claim", rv, 32'd1);
    bus_wr(REG_CLAIM, 32'd1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
